fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the 8-bit FIFO. Pops one byte whenever the FIFO is non-empty and
//  serialises it onto an asynchronous line: 1 start bit, 8 data bits LSB first, optional parity,
//  then 1 or 2 stop bits. Connects to the FIFO read side: en_read, data_out and underflow (empty).
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  STOP_BITS     1   stop bits per frame; 1 or 2
//  PARITY_EN     0   1 = insert a parity bit after D7
//  PARITY_ODD    0   1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
// PORTS
//  clk         in   1  single clock; all state updates on the rising edge
//  reset       in   1  synchronous, active-high reset
//  enable      in   1  1 = start new frames; 0 = finish the current frame, then hold in IDLE
//  fifo_empty  in   1  FIFO empty flag (the FIFO's underflow output)
//  fifo_data   in   8  FIFO read data (the FIFO's data_out)
//  fifo_rd_en  out  1  one-cycle pop request (drives the FIFO's en_read)
//  tx          out  1  serial line; idles high
//  busy        out  1  1 in every state except IDLE
//  byte_done   out  1  one-cycle pulse on the last clk of the final stop bit
// BEHAVIOUR
//  Reset (synchronous): state=IDLE; tx=1, fifo_rd_en=0, busy=0, byte_done=0; counters cleared.
//  FIFO contract:
//   - fifo_data is valid only in the cycle after fifo_rd_en=1; it reads 0 at all other times.
//   - fifo_empty is registered and is correct from 2 cycles after a pop.
//   - The block never pops twice within 3 cycles and never samples fifo_empty within 2 cycles of a pop.
//  FSM: IDLE -> REQ -> CAPTURE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   IDLE:    go to REQ when enable=1 and fifo_empty=0.
//   REQ:     fifo_rd_en=1 for exactly this one cycle; tx=1.
//   CAPTURE: shift_reg <= fifo_data; parity computed from fifo_data; tx=1.
//   START:   tx=0 for CLKS_PER_BIT cycles.
//   DATA:    tx=shift_reg[bit_idx], bit_idx 0..7, CLKS_PER_BIT cycles per bit.
//   PARITY:  tx = ^data XOR PARITY_ODD, for CLKS_PER_BIT cycles.
//   STOP:    tx=1 for STOP_BITS*CLKS_PER_BIT cycles; byte_done on the final cycle, then IDLE.
//  Outputs fifo_rd_en, tx and byte_done are registered; no combinational path from input to output.
//  Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0 with a tick.
//   Counter clears on every state entry, so every bit lasts exactly CLKS_PER_BIT cycles.
//  Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
//  Back-to-back bytes: exactly 3 idle-high cycles (IDLE, REQ, CAPTURE) between stop end and next start.
//  enable=0 mid-frame: the frame completes unchanged; no further REQ is issued.
//   enable is sampled only in IDLE.
//  fifo_empty changing mid-frame: ignored; it is sampled only in IDLE.
//  Reset mid-frame: tx=1 on the next edge; the in-flight byte is dropped (already popped).
//  First-byte latency: enable=1, fifo_empty=0 in IDLE -> tx falls 3 clk later.
// STRUCTURE
//  Shared package fifo_uart_pkg:
//   - state encoding constants (IDLE..STOP, 3-bit)
//   - DATA_W=8
//   - frame-length helper function
//  Sub-module baud_tick_gen (parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick).
//  Top level: FSM, 8-bit shift_reg, 3-bit bit_idx, 1-bit stop_cnt, parity register.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1. Reset held 3 clk with enable=1 and fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0, byte_done=0 throughout.
//  2. Single byte 0xA5 -> exactly one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 at 4 clk each;
//     byte_done 40 clk after tx falls; busy=0 afterwards.
//  3. FIFO holds 0x01 then 0x80 -> two frames separated by exactly 3 tx-high cycles;
//     exactly 2 pops; second data field = 0,0,0,0,0,0,0,1.
//  4. enable dropped 5 clk into frame 0x3C with the FIFO non-empty -> frame completes intact;
//     no further fifo_rd_en while enable=0.
//  5. PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, byte 0x03 -> parity bit 1;
//     stop high for 8 clk; frame 48 clk.
//  6. reset pulsed during DATA bit 3 -> tx=1 and busy=0 on the next edge;
//     next byte transmits correctly with no extra pop.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and helpers for the FIFO-fed UART transmitter
// Contents: DATA_W, FSM state encoding, frame-length helper.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_START   = 3'd3,
    ST_DATA    = 3'd4,
    ST_PARITY  = 3'd5,
    ST_STOP    = 3'd6
  } tx_state_e;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_clks(input int clks_per_bit, input int parity_en,
                                    input int stop_bits);
    return (10 + parity_en + stop_bits - 1) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-side bundle between a byte FIFO and the UART transmitter
// Signals:
//   fifo_rd_en  one-cycle pop request (consumer -> FIFO)
//   fifo_empty  registered FIFO empty flag (FIFO -> consumer)
//   fifo_data   read data, valid the cycle after fifo_rd_en (FIFO -> consumer)
// Modports: master = consumer (transmitter), slave = FIFO.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );

endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter producing one tick per CLKS_PER_BIT cycles
// Ports:
//   clk       in  clock
//   reset     in  synchronous active-high reset
//   clear     in  restart the bit period (counter to 0 on the next edge)
//   tick      out high in the last cycle of each bit period
//   pre_tick  out high in the cycle before tick (lets the caller register tick-aligned outputs)
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a FIFO and serialises them as async UART frames
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   enable     in   1 = start new frames; sampled only in IDLE
//   fifo       if   FIFO read side (master modport): fifo_rd_en, fifo_empty, fifo_data
//   tx         out  serial line, idles high (registered)
//   busy       out  1 in every state except IDLE
//   byte_done  out  one-cycle pulse on the last clk of the final stop bit (registered)
// Frame: start, D0..D7 LSB first, optional parity, STOP_BITS stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  localparam logic LAST_STOP  = (STOP_BITS == 2);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);

  tx_state_e         state, state_n;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx, bit_idx_n;
  logic              stop_cnt, stop_cnt_n;
  logic              parity_bit;
  logic              tick, pre_tick;
  logic              baud_clear;
  logic              tx_n, rd_en_n, byte_done_n;
  logic              rd_en_q;

  // Restarting the bit period on every state change keeps each bit exactly
  // CLKS_PER_BIT long regardless of how long IDLE/REQ/CAPTURE took.
  assign baud_clear = (state_n != state);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo.fifo_empty) state_n = ST_REQ;
      end
      ST_REQ:     state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = ST_START;
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          bit_idx_n = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_n    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            stop_cnt_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n    = ST_STOP;
          stop_cnt_n = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) state_n = ST_IDLE;
          else                       stop_cnt_n = stop_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered versions line
  // up with the state they belong to.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_reg[bit_idx_n];
      ST_PARITY: tx_n = parity_bit;
      default:   tx_n = 1'b1;
    endcase
    rd_en_n     = (state_n == ST_REQ);
    // pre_tick in the final stop bit means the next cycle is its last one.
    byte_done_n = (state == ST_STOP) && (stop_cnt == LAST_STOP) && pre_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= 3'd0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      rd_en_q    <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      stop_cnt  <= stop_cnt_n;
      tx        <= tx_n;
      rd_en_q   <= rd_en_n;
      byte_done <= byte_done_n;
      // fifo_data is only valid in the cycle after the pop, i.e. CAPTURE.
      if (state == ST_CAPTURE) begin
        shift_reg  <= fifo.fifo_data;
        parity_bit <= (^fifo.fifo_data) ^ ODD_PARITY;
      end
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx (two parameterisations)
module tb_fifo_uart_tx;

  localparam int CPB    = 4;
  localparam int FLEN_A = 40;  // 10 bits * 4
  localparam int FLEN_B = 48;  // 12 bits * 4 (parity + 2 stop)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en_a, en_b;
  logic tx_a, busy_a, bd_a;
  logic tx_b, busy_b, bd_b;

  fifo_uart_tx_if if_a ();
  fifo_uart_tx_if if_b ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .fifo(if_a),
    .tx(tx_a), .busy(busy_a), .byte_done(bd_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .fifo(if_b),
    .tx(tx_b), .busy(busy_b), .byte_done(bd_b)
  );

  logic [7:0] fq_a[$], fq_b[$];
  logic [7:0] sb_a[$], sb_b[$];
  int pops_a, pops_b;
  int n_checks, n_pass;

  int in_frame[2], cyc[2], bad[2], bad_val[2], bd_idx[2], bd_cnt[2];
  int idle_run[2], gap[2], frames_done[2], last_len[2];
  logic [11:0] fbits[2];
  logic [7:0]  cur_byte[2];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
  endtask

  task automatic fifo_model();
    logic ra, rb;
    forever begin
      @(negedge clk);
      ra = if_a.fifo_rd_en;
      rb = if_b.fifo_rd_en;
      @(posedge clk);
      #1;
      if (ra) begin
        pops_a++;
        if_a.fifo_data = (fq_a.size() > 0) ? fq_a.pop_front() : 8'h00;
      end else begin
        if_a.fifo_data = 8'h00;
      end
      if (rb) begin
        pops_b++;
        if_b.fifo_data = (fq_b.size() > 0) ? fq_b.pop_front() : 8'h00;
      end else begin
        if_b.fifo_data = 8'h00;
      end
      if_a.fifo_empty = (fq_a.size() == 0);
      if_b.fifo_empty = (fq_b.size() == 0);
    end
  endtask

  task automatic mon_step(input int g);
    logic t, bd;
    logic [7:0] b;
    int flen, bi;
    t    = (g == 0) ? tx_a : tx_b;
    bd   = (g == 0) ? bd_a : bd_b;
    flen = (g == 0) ? FLEN_A : FLEN_B;
    if (reset) begin
      in_frame[g] = 0;
      idle_run[g] = 0;
      return;
    end
    if (in_frame[g] == 0) begin
      if (bd) check(1'b0, $sformatf("inst%0d byte_done outside frame", g), 1, 0);
      if (t == 1'b0) begin
        if (((g == 0) ? sb_a.size() : sb_b.size()) == 0) begin
          check(1'b0, $sformatf("inst%0d unexpected frame start", g), 1, 0);
          b = 8'h00;
        end else begin
          b = (g == 0) ? sb_a.pop_front() : sb_b.pop_front();
        end
        cur_byte[g]   = b;
        fbits[g]      = '1;
        fbits[g][0]   = 1'b0;
        fbits[g][8:1] = b;
        if (g == 1) fbits[g][9] = (^b) ^ 1'b1;
        in_frame[g] = 1;
        cyc[g]      = 0;
        bad[g]      = 0;
        bd_idx[g]   = -1;
        bd_cnt[g]   = 0;
        gap[g]      = idle_run[g];
      end else begin
        idle_run[g]++;
      end
    end
    if (in_frame[g] != 0) begin
      bi = cyc[g] / CPB;
      if (t !== fbits[g][bi] && bad[g] == 0) begin
        bad[g]     = 1;
        bad_val[g] = int'(t);
      end
      if (bd) begin
        bd_cnt[g]++;
        bd_idx[g] = cyc[g];
      end
      if (cyc[g] % CPB == CPB - 1) begin
        check(bad[g] == 0, $sformatf("inst%0d byte %02h frame bit %0d", g, cur_byte[g], bi),
              (bad[g] != 0) ? bad_val[g] : int'(t), int'(fbits[g][bi]));
        bad[g] = 0;
      end
      if (cyc[g] == flen - 1) begin
        check(bd_cnt[g] == 1 && bd_idx[g] == flen - 1,
              $sformatf("inst%0d byte_done cycle", g), bd_idx[g], flen - 1);
        last_len[g] = bd_idx[g] + 1;
        in_frame[g] = 0;
        idle_run[g] = 0;
        frames_done[g]++;
      end
      cyc[g]++;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_step(0);
      mon_step(1);
    end
  endtask

  task automatic wait_frames(input int g, input int n, input string name);
    int k = 0;
    while (frames_done[g] < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(frames_done[g] >= n, name, frames_done[g], n);
  endtask

  task automatic wait_start(input int g, input string name);
    int k = 0;
    while (in_frame[g] == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(in_frame[g] != 0, name, in_frame[g], 1);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    en_a  = 1'b1;
    en_b  = 1'b0;
    if_a.fifo_data  = 8'h00;
    if_b.fifo_data  = 8'h00;
    if_a.fifo_empty = 1'b1;
    if_b.fifo_empty = 1'b1;
    fq_a.push_back(8'hA5);
    sb_a.push_back(8'hA5);
    fork
      fifo_model();
      monitor();
    join_none

    // Reset held with enable=1 and a non-empty FIFO: everything stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(tx_a == 1'b1 && busy_a == 1'b0 && if_a.fifo_rd_en == 1'b0 && bd_a == 1'b0,
            "reset outputs inst0", int'({tx_a, busy_a, if_a.fifo_rd_en, bd_a}), 8);
      check(tx_b == 1'b1 && busy_b == 1'b0 && if_b.fifo_rd_en == 1'b0 && bd_b == 1'b0,
            "reset outputs inst1", int'({tx_b, busy_b, if_b.fifo_rd_en, bd_b}), 8);
    end
    #2 reset = 1'b0;

    // Single byte 0xA5 and first-byte latency.
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_a !== 1'b0 && lat < 20);
    check(lat == 3, "first byte latency", lat, 3);
    wait_frames(0, 1, "frame 0xA5 done");
    @(negedge clk);
    check(pops_a == 1, "pops after 0xA5", pops_a, 1);
    check(busy_a == 1'b0, "busy after 0xA5", int'(busy_a), 0);

    // Back-to-back 0x01, 0x80.
    fq_a.push_back(8'h01); sb_a.push_back(8'h01);
    fq_a.push_back(8'h80); sb_a.push_back(8'h80);
    wait_frames(0, 3, "frames 0x01 0x80 done");
    check(gap[0] == 3, "back-to-back idle gap", gap[0], 3);
    @(negedge clk);
    check(pops_a == 3, "pops after 0x01 0x80", pops_a, 3);

    // enable dropped 5 clk into frame 0x3C with more data waiting.
    fq_a.push_back(8'h3C); sb_a.push_back(8'h3C);
    fq_a.push_back(8'h55);
    wait_start(0, "frame 0x3C start");
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    wait_frames(0, 4, "frame 0x3C done");
    repeat (30) @(negedge clk);
    check(pops_a == 4, "no pop while disabled", pops_a, 4);
    check(busy_a == 1'b0 && tx_a == 1'b1, "idle while disabled", int'({busy_a, tx_a}), 1);
    check(fq_a.size() == 1, "fifo still holds 0x55", fq_a.size(), 1);

    // Reset during DATA bit 3 of 0x55, then 0x96 transmits cleanly.
    sb_a.push_back(8'h55);
    en_a = 1'b1;
    wait_start(0, "frame 0x55 start");
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check(tx_a == 1'b1 && busy_a == 1'b0, "mid-frame reset idles", int'({tx_a, busy_a}), 2);
    #2 reset = 1'b0;
    check(pops_a == 5, "pops after aborted 0x55", pops_a, 5);
    @(negedge clk);
    fq_a.push_back(8'h96); sb_a.push_back(8'h96);
    wait_frames(0, 5, "frame 0x96 done");
    @(negedge clk);
    check(pops_a == 6, "pops after 0x96", pops_a, 6);
    check(sb_a.size() == 0, "scoreboard drained inst0", sb_a.size(), 0);

    // Odd parity, two stop bits, byte 0x03.
    en_b = 1'b1;
    fq_b.push_back(8'h03); sb_b.push_back(8'h03);
    wait_frames(1, 1, "frame 0x03 parity done");
    check(last_len[1] == 48, "parity frame length", last_len[1], 48);
    @(negedge clk);
    check(pops_b == 1, "pops inst1", pops_b, 1);
    check(busy_b == 1'b0, "busy after parity frame", int'(busy_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
